// File: rtl/m_seq_divider_pkg.sv
// Shared types and constants for the sequential divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

  // Operand/result width of the default build; one restoring step per bit.
  localparam int DIV_W = 8;

  // Width of the step counter that walks WIDTH-1 down to 0.
  localparam int DIV_CNT_W = $clog2(DIV_W);

  // Quotient reported on a zero divisor (all ones, -1 when signed).
  localparam logic [DIV_W-1:0] DIV_Q_DBZ = '1;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIN
  } div_state_e;

endpackage

// File: rtl/m_seq_divider_if.sv
// Request/result bundle between issue control (master) and the divider (slave).
// Latency: n/a (wires only).
// Backpressure: master holds off while busy is high; start during busy is dropped.
interface m_seq_divider_if #(
  parameter int WIDTH = div_pkg::DIV_W
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/m_seq_divider_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
// Latency: combinational.
// Backpressure: none.
module m_div_step #(
  parameter int WIDTH = div_pkg::DIV_W
) (
  input  logic [WIDTH:0]   r_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_out,
  output logic             q_bit
);

  // Kept one bit wider than the register so every input bit takes part in the compare.
  logic [WIDTH+1:0] r_shift;
  logic [WIDTH+1:0] d_ext;

  assign r_shift = {r_in, q_msb};
  assign d_ext   = (WIDTH+2)'(d);

  // Trial subtraction; restore (keep shifted value) when the divisor does not fit.
  always_comb begin
    q_bit = (r_shift >= d_ext);
    r_out = (WIDTH+1)'(q_bit ? (r_shift - d_ext) : r_shift);
  end

endmodule

// File: rtl/m_seq_divider.sv
// Multi-cycle restoring divider (unsigned; two's complement when SEQ_DIVIDER_SIGNED_EN is defined).
// Latency: WIDTH+1 cycles from accept to done; 1 cycle for a zero divisor.
// Backpressure: busy high until done inclusive; start while busy (or in done cycle) is ignored.
module m_seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic           clk,
  input  logic           reset,   // synchronous, active low
  m_seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;      // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;      // latched divisor (magnitude when signed)
  logic [WIDTH-1:0] q_res_q, q_res_d;
  logic [WIDTH-1:0] r_res_q, r_res_d;
  logic             dbz_q, dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             neg_q_q, neg_q_d;  // quotient needs negation at finish
  logic             neg_r_q, neg_r_d;  // remainder takes the dividend's sign
`endif

  logic [WIDTH:0]   step_r;
  logic             step_q_bit;
  logic [WIDTH-1:0] quo_step;

  m_div_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (rem_q),
    .q_msb (quo_q[WIDTH-1]),
    .d     (dvs_q),
    .r_out (step_r),
    .q_bit (step_q_bit)
  );

  assign quo_step = {quo_q[WIDTH-2:0], step_q_bit};

  // Next-state logic: accept in IDLE, one step per CALC cycle, results loaded on FIN entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_res_d = q_res_q;
    r_res_d = r_res_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif
    case (state_q)
      DIV_IDLE: begin
        if (bus.start) begin
          dbz_d = 1'b0;
          if (bus.divisor == '0) begin
            // Zero divisor skips the iteration entirely.
            state_d = DIV_FIN;
            q_res_d = '1;
            r_res_d = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = DIV_CALC;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH-1);
`ifdef SEQ_DIVIDER_SIGNED_EN
            quo_d   = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
            dvs_d   = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
            neg_q_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_r_d = bus.dividend[WIDTH-1];
`else
            quo_d   = bus.dividend;
            dvs_d   = bus.divisor;
`endif
          end
        end
      end
      DIV_CALC: begin
        rem_d = step_r;
        quo_d = quo_step;
        if (cnt_q == '0) begin
          // Last step: publish results on the same edge FIN is entered.
          state_d = DIV_FIN;
`ifdef SEQ_DIVIDER_SIGNED_EN
          q_res_d = neg_q_q ? -quo_step : quo_step;
          r_res_d = neg_r_q ? -step_r[WIDTH-1:0] : step_r[WIDTH-1:0];
`else
          q_res_d = quo_step;
          r_res_d = step_r[WIDTH-1:0];
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DIV_FIN: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_res_q <= '0;
      r_res_q <= '0;
      dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_res_q <= q_res_d;
      r_res_q <= r_res_d;
      dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

  assign bus.busy        = (state_q != DIV_IDLE);
  assign bus.done        = (state_q == DIV_FIN);
  assign bus.quotient    = q_res_q;
  assign bus.remainder   = r_res_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_m_seq_divider.sv
// Bench for m_seq_divider: directed and random divisions against an arithmetic model.
// Latency: checks done arrives WIDTH cycles after the accept edge (0 for zero divisor).
// Backpressure: checks start pulses during busy and in the done cycle are dropped.
module tb_m_seq_divider;
  import div_pkg::*;

  localparam int W = DIV_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   passed = 0;

  logic [W-1:0] exp_q, exp_r, prev_q, prev_r;
  logic         exp_dbz, prev_dbz;
  int           done_seen;

  m_seq_divider_if #(.WIDTH(W)) bus ();

  m_seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: plain language-level division, zero divisor handled explicitly.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    int sa, sb, qi, ri;
    if (b == '0) begin
      q = DIV_Q_DBZ;
      r = a;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      qi = sa / sb;
      ri = sa % sb;
      q  = W'(qi);
      r  = W'(ri);
    end
  endfunction

  // Present operands with start for one edge, then scramble the operand ports.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    model(a, b, exp_q, exp_r);
    exp_dbz = (b == '0);
  endtask

  // Wait for done (bounded), check latency/results, poke start in the done cycle.
  task automatic finish_op(input string tag, input int elapsed);
    int lat;
    lat = elapsed;
    while (bus.done !== 1'b1 && lat < 40) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_held_q"}, 32'(bus.quotient), 32'(prev_q));
      chk({tag, "_dbz_clr"}, 32'(bus.div_by_zero), 32'd0);
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), exp_dbz ? 32'd0 : 32'(W));
    chk({tag, "_busy_fin"}, 32'(bus.busy), 32'd1);
    chk({tag, "_q"}, 32'(bus.quotient), 32'(exp_q));
    chk({tag, "_r"}, 32'(bus.remainder), 32'(exp_r));
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
    bus.start    = 1'b1;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom_range(1, 255));
    tick();
    bus.start = 1'b0;
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, "_hold_q"}, 32'(bus.quotient), 32'(exp_q));
    chk({tag, "_hold_r"}, 32'(bus.remainder), 32'(exp_r));
    chk({tag, "_hold_dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
    prev_q   = exp_q;
    prev_r   = exp_r;
    prev_dbz = exp_dbz;
  endtask

  initial begin
    logic [W-1:0] a, b;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    prev_q = '0;
    prev_r = '0;
    prev_dbz = 1'b0;

    // Reset state
    tick();
    tick();
    reset = 1'b1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_q", 32'(bus.quotient), 32'd0);
    chk("rst_r", 32'(bus.remainder), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    issue(8'hF9, 8'd2);   finish_op("s_m7_2", 0);
    issue(8'd7, 8'hFE);   finish_op("s_7_m2", 0);
    issue(8'h80, 8'hFF);  finish_op("s_min_m1", 0);
    chk("s_min_m1_model_q", 32'(prev_q), 32'h80);
`endif

    // Basic division, then back-to-back pair, then divide by zero
    issue(8'd100, 8'd7);  finish_op("d100_7", 0);
    issue(8'd255, 8'd1);  finish_op("d255_1", 0);
    issue(8'd5, 8'd10);   finish_op("d5_10", 0);
    issue(8'd42, 8'd0);   finish_op("d42_0", 0);

    // Start pulse while busy must be ignored
    issue(8'd200, 8'd3);
    tick();
    tick();
    bus.dividend = 8'd9;
    bus.divisor  = 8'd9;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    finish_op("d200_3_restart", 3);

    // Reset mid-operation aborts with no done
    issue(8'd77, 8'd5);
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_q", 32'(bus.quotient), 32'd0);
    chk("abort_r", 32'(bus.remainder), 32'd0);
    chk("abort_dbz", 32'(bus.div_by_zero), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1) done_seen++;
      tick();
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    prev_q = '0;
    prev_r = '0;
    prev_dbz = 1'b0;

    // Randomized operations, some with zero divisor, issued back to back
    for (int n = 0; n < 25; n++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      issue(a, b);
      finish_op($sformatf("rnd%0d", n), 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
